// File: rtl/data_check.sv
// ---------------------------------------------------------------------------
// data_check -- incrementing-sequence checker with lock/loss hysteresis.
//
// The received word is expected to count up by one (mod 2^WIDTH) on each
// qualified sample. In HUNT the checker looks for LOCK_THRESH consecutive
// in-sequence increments. Once it has them it moves to LOCKED. In LOCKED it
// flags every mismatched sample and counts samples and errors. After
// LOSS_THRESH consecutive mismatches it falls back to HUNT.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   en         : sample qualifier; nothing moves on cycles with en=0
//   data       : received word (WIDTH bits)
//   clr        : synchronous clear of err_count / word_count (wins over +1)
//   locked     : high while in LOCKED
//   err        : one-cycle pulse, registered, per mismatched sample in LOCKED
//   err_count  : saturating mismatch count (CNT_W bits)
//   word_count : saturating count of samples taken while LOCKED (CNT_W bits)
// ---------------------------------------------------------------------------
module data_check #(
  parameter int WIDTH       = 6,
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  // Run counters only need to reach their thresholds.
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int SW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q,     state_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] exp_q,       exp_d;
  logic [MW-1:0]    match_q,     match_d;
  logic [SW-1:0]    miss_q,      miss_d;
  logic             err_q,       err_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;

  logic          hit;
  logic          miss_ev;
  logic          word_ev;
  logic [MW-1:0] match_inc;
  logic [SW-1:0] miss_inc;

  assign hit       = (data == exp_q);
  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      have_prev_q <= 1'b0;
      exp_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      exp_q       <= exp_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    exp_d       = exp_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    miss_ev     = 1'b0;
    word_ev     = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          // While hunting, exp always tracks the last word + 1. The next
          // sample is therefore judged only against its predecessor.
          exp_d = data + 1'b1;
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
          end else if (hit) begin
            if (match_inc == MW'(LOCK_THRESH)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          // exp free-runs so one corrupt word costs exactly one error,
          // instead of also poisoning the comparison for the next word.
          word_ev = 1'b1;
          exp_d   = exp_q + 1'b1;
          if (!hit) begin
            err_d   = 1'b1;
            miss_ev = 1'b1;
            if (miss_inc == SW'(LOSS_THRESH)) begin
              state_d     = HUNT;
              have_prev_d = 1'b0;
              match_d     = '0;
              miss_d      = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // Statistics counters saturate at all-ones. clr takes priority over an
  // increment in the same cycle.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (miss_ev && !(&err_cnt_q))  err_cnt_d  = err_cnt_q + 1'b1;
    if (word_ev && !(&word_cnt_q)) word_cnt_d = word_cnt_q + 1'b1;
    if (clr) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    locked     = (state_q == LOCKED);
    err        = err_q;
    err_count  = err_cnt_q;
    word_count = word_cnt_q;
  end

endmodule

// File: tb/tb_data_check.sv
// ---------------------------------------------------------------------------
// tb_data_check -- directed plus randomized bench for data_check.
// Two instances share stimulus: the default build and one with CNT_W=4, so
// counter saturation is reachable. The reference model tracks lock status,
// the previous word and unbounded integer counts. Saturated counters are
// compared against min(count, max).
// ---------------------------------------------------------------------------
module tb_data_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] data;
  logic       clr;

  logic        locked,  err;
  logic [15:0] err_count,  word_count;
  logic        locked4, err4;
  logic [3:0]  err_count4, word_count4;

  always #5 clk = ~clk;

  data_check dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .clr(clr),
    .locked(locked), .err(err), .err_count(err_count), .word_count(word_count)
  );

  data_check #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .data(data), .clr(clr),
    .locked(locked4), .err(err4), .err_count(err_count4), .word_count(word_count4)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_locked;
  bit m_have;
  int m_prev;
  int m_exp;
  int m_run;
  int m_miss;
  bit m_err;
  int m_errs;
  int m_words;

  int nxt;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_prev = 0; m_exp = 0;
    m_run = 0; m_miss = 0; m_err = 0; m_errs = 0; m_words = 0;
  endtask

  task automatic model_step(input bit e, input int d, input bit c);
    m_err = 0;
    if (e) begin
      if (!m_locked) begin
        if (!m_have) m_have = 1;
        else if (d == (m_prev + 1) % 64) begin
          m_run++;
          if (m_run == 4) begin
            m_locked = 1;
            m_run    = 0;
            m_miss   = 0;
            m_exp    = (d + 1) % 64;
          end
        end else m_run = 0;
        m_prev = d;
      end else begin
        m_words++;
        if (d != m_exp) begin
          m_err = 1;
          m_errs++;
          m_miss++;
          if (m_miss == 3) begin
            m_locked = 0; m_have = 0; m_run = 0; m_miss = 0;
          end
        end else m_miss = 0;
        m_exp = (m_exp + 1) % 64;
      end
    end
    if (c) begin
      m_errs  = 0;
      m_words = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},     32'(locked),      32'(m_locked));
    chk({tag, ".err"},        32'(err),         32'(m_err));
    chk({tag, ".err_count"},  32'(err_count),   32'(sat(m_errs, 65535)));
    chk({tag, ".word_count"}, 32'(word_count),  32'(sat(m_words, 65535)));
    chk({tag, ".locked4"},    32'(locked4),     32'(m_locked));
    chk({tag, ".err_cnt4"},   32'(err_count4),  32'(sat(m_errs, 15)));
    chk({tag, ".word_cnt4"},  32'(word_count4), 32'(sat(m_words, 15)));
  endtask

  task automatic step(input bit e, input int d, input bit c, input string tag);
    @(negedge clk);
    en   = e;
    data = d[5:0];
    clr  = c;
    @(posedge clk);
    #1;
    model_step(e, d % 64, c);
    check_all(tag);
  endtask

  initial begin
    int w0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; data = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // initial lock on 0..4
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i, 1'b0, "lock_seq");
      if (i == 3) chk("lock_not_yet", 32'(locked), 32'd0);
    end
    chk("lock_rise", 32'(locked), 32'd1);
    nxt = 5;

    // in-sequence run through the wrap 63 -> 0
    while (nxt != 61) begin step(1'b1, nxt, 1'b0, "run"); nxt = (nxt + 1) % 64; end
    w0 = int'(word_count);
    for (int i = 0; i < 5; i++) begin step(1'b1, nxt, 1'b0, "wrap"); nxt = (nxt + 1) % 64; end
    chk("wrap_words", 32'(word_count), 32'(w0 + 5));
    chk("wrap_locked", 32'(locked), 32'd1);

    // a single corrupt word in 10..14
    while (nxt != 10) begin step(1'b1, nxt, 1'b0, "run"); nxt = (nxt + 1) % 64; end
    step(1'b1, 10, 1'b0, "one_bad"); step(1'b1, 11, 1'b0, "one_bad");
    step(1'b1, 40, 1'b0, "one_bad");
    chk("one_bad_err", 32'(err), 32'd1);
    step(1'b1, 13, 1'b0, "one_bad"); step(1'b1, 14, 1'b0, "one_bad");
    chk("one_bad_cnt", 32'(err_count), 32'd1);
    chk("one_bad_locked", 32'(locked), 32'd1);
    nxt = 15;

    // three consecutive wrong words drop lock, then five good relock
    for (int i = 0; i < 3; i++) begin step(1'b1, (nxt + 7) % 64, 1'b0, "loss"); nxt = (nxt + 1) % 64; end
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_cnt", 32'(err_count), 32'd4);
    for (int i = 0; i < 5; i++) begin step(1'b1, nxt, 1'b0, "relock"); nxt = (nxt + 1) % 64; end
    chk("relock", 32'(locked), 32'd1);

    // clr coinciding with a locked mismatch
    step(1'b1, (nxt + 9) % 64, 1'b1, "clr_err");
    nxt = (nxt + 1) % 64;
    chk("clr_err_cnt", 32'(err_count), 32'd0);
    chk("clr_word_cnt", 32'(word_count), 32'd0);
    chk("clr_err_pulse", 32'(err), 32'd1);

    // 20 non-consecutive mismatches saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (nxt + 30) % 64, 1'b0, "sat");
      step(1'b1, (nxt + 1) % 64, 1'b0, "sat");
      nxt = (nxt + 2) % 64;
    end
    chk("sat_cnt4", 32'(err_count4), 32'd15);
    chk("sat_cnt16", 32'(err_count), 32'd20);

    // en gaps do not break lock
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin step(1'b1, nxt, 1'b0, "gap"); nxt = (nxt + 1) % 64; end
      else step(1'b0, int'($urandom_range(0, 63)), 1'b0, "gap");
    end
    chk("gap_locked", 32'(locked), 32'd1);

    // randomized mix of good / bad words, gaps and clears
    for (int i = 0; i < 1500; i++) begin
      bit e, c;
      int d;
      e = ($urandom_range(0, 3) != 0);
      c = e && ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) < 85) d = nxt;
      else d = int'($urandom_range(0, 63));
      step(e, d, c, "rand");
      if (e) nxt = (d + 1) % 64;
    end

    // reset asserted between edges while locked
    for (int i = 0; i < 12; i++) begin step(1'b1, nxt, 1'b0, "pre_rst"); nxt = (nxt + 1) % 64; end
    chk("pre_rst_locked", 32'(locked), 32'd1);
    step(1'b1, (nxt + 5) % 64, 1'b0, "pre_rst_bad");
    nxt = (nxt + 1) % 64;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, nxt, 1'b0, "post_rst");
      nxt = (nxt + 1) % 64;
      if (i == 3) chk("post_rst_not_yet", 32'(locked), 32'd0);
    end
    chk("post_rst_lock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
